armleocpu_simple2axi_converter: RTL and testbench

Initiator-side bridge that turns a single-outstanding simple request (address, read/write, data, byte enables) into a single-beat AXI4 transaction and returns read data plus response code. It is the master-side counterpart of the simple-to-AXI responder path used by peripherals, and sits between CPU-side/debug request sources and the AXI interconnect. One transaction in flight at a time; all AXI outputs are registered.

---
 rtl/armleocpu_simple2axi_converter_pkg.sv | 26 ++
 rtl/armleocpu_simple2axi_converter_if.sv | 86 ++++++++
 rtl/armleocpu_simple2axi_converter.sv | 163 ++++++++++++++++
 tb/tb_armleocpu_simple2axi_converter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/armleocpu_simple2axi_converter_pkg.sv
// Shared constants and state type for the simple-request to single-beat AXI4 bridge.
// AXI burst/response/size encodings live here so the bridge and its users agree on them.
package armleocpu_simple2axi_converter_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int DATA_STROBES = DATA_WIDTH / 8;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;

    typedef enum logic [2:0] {
        STATE_IDLE,
        STATE_WRITE_ADDR_DATA,
        STATE_WRITE_RESP,
        STATE_READ_ADDR,
        STATE_READ_DATA,
        STATE_RESPOND
    } state_t;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/armleocpu_simple2axi_converter_if.sv
// Bundle of the simple request/response port and the AXI4 master port of the bridge.
// The master modport is the bridge's view; slave is the requester/interconnect view.
interface armleocpu_simple2axi_converter_if #(
    parameter int ADDR_WIDTH = 34,
    parameter int ID_WIDTH   = 4
);
    import armleocpu_simple2axi_converter_pkg::*;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [ADDR_WIDTH-1:0]   cmd_address;
    logic [DATA_WIDTH-1:0]   cmd_write_data;
    logic [DATA_STROBES-1:0] cmd_write_byteenable;

    logic                    resp_valid;
    logic [DATA_WIDTH-1:0]   resp_read_data;
    logic [1:0]              resp_code;

    logic                    axi_awvalid;
    logic                    axi_awready;
    logic [ADDR_WIDTH-1:0]   axi_awaddr;
    logic [ID_WIDTH-1:0]     axi_awid;
    logic [7:0]              axi_awlen;
    logic [2:0]              axi_awsize;
    logic [1:0]              axi_awburst;

    logic                    axi_wvalid;
    logic                    axi_wready;
    logic [DATA_WIDTH-1:0]   axi_wdata;
    logic [DATA_STROBES-1:0] axi_wstrb;
    logic                    axi_wlast;

    logic                    axi_bvalid;
    logic                    axi_bready;
    logic [1:0]              axi_bresp;
    logic [ID_WIDTH-1:0]     axi_bid;

    logic                    axi_arvalid;
    logic                    axi_arready;
    logic [ADDR_WIDTH-1:0]   axi_araddr;
    logic [ID_WIDTH-1:0]     axi_arid;
    logic [7:0]              axi_arlen;
    logic [2:0]              axi_arsize;
    logic [1:0]              axi_arburst;

    logic                    axi_rvalid;
    logic                    axi_rready;
    logic [1:0]              axi_rresp;
    logic [ID_WIDTH-1:0]     axi_rid;
    logic [DATA_WIDTH-1:0]   axi_rdata;
    logic                    axi_rlast;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_write_data, cmd_write_byteenable,
        output cmd_ready,
        output resp_valid, resp_read_data, resp_code,
        output axi_awvalid, axi_awaddr, axi_awid, axi_awlen, axi_awsize, axi_awburst,
        input  axi_awready,
        output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
        input  axi_wready,
        input  axi_bvalid, axi_bresp, axi_bid,
        output axi_bready,
        output axi_arvalid, axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst,
        input  axi_arready,
        input  axi_rvalid, axi_rresp, axi_rid, axi_rdata, axi_rlast,
        output axi_rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_write_data, cmd_write_byteenable,
        input  cmd_ready,
        input  resp_valid, resp_read_data, resp_code,
        input  axi_awvalid, axi_awaddr, axi_awid, axi_awlen, axi_awsize, axi_awburst,
        output axi_awready,
        input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
        output axi_wready,
        output axi_bvalid, axi_bresp, axi_bid,
        input  axi_bready,
        input  axi_arvalid, axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst,
        output axi_arready,
        output axi_rvalid, axi_rresp, axi_rid, axi_rdata, axi_rlast,
        input  axi_rready
    );

endinterface

// File: rtl/armleocpu_simple2axi_converter.sv
// Single-outstanding bridge: one simple request becomes one single-beat AXI4 read or write.
// Every AXI output and the response port come straight from flops.
module armleocpu_simple2axi_converter
    import armleocpu_simple2axi_converter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 34,
    parameter int ID_WIDTH       = 4,
    parameter int TRANSACTION_ID = 0
) (
    input  logic clk,
    input  logic rst_n,
    armleocpu_simple2axi_converter_if.master bus
);

    localparam logic [ID_WIDTH-1:0] TID = ID_WIDTH'(TRANSACTION_ID);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_STROBES-1:0] wstrb_q, wstrb_d;
    logic                    aw_valid_q, aw_valid_d;
    logic                    w_valid_q, w_valid_d;
    logic                    b_ready_q, b_ready_d;
    logic                    ar_valid_q, ar_valid_d;
    logic                    r_ready_q, r_ready_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
    logic [1:0]              resp_code_q, resp_code_d;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_valid_d   = aw_valid_q;
        w_valid_d    = w_valid_q;
        b_ready_d    = b_ready_q;
        ar_valid_d   = ar_valid_q;
        r_ready_d    = r_ready_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_code_d  = resp_code_q;
        case (state_q)
            STATE_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d      = bus.cmd_address;
                    wdata_d     = bus.cmd_write_data;
                    wstrb_d     = bus.cmd_write_byteenable;
                    resp_data_d = '0;
                    // Misaligned requests never reach the bus
                    if (!is_word_aligned(bus.cmd_address[1:0])) begin
                        state_d      = STATE_RESPOND;
                        resp_valid_d = 1'b1;
                        resp_code_d  = AXI_RESP_SLVERR;
                    end else if (bus.cmd_write) begin
                        state_d    = STATE_WRITE_ADDR_DATA;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        state_d    = STATE_READ_ADDR;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            STATE_WRITE_ADDR_DATA: begin
                // A dropped valid doubles as that channel's done flag
                if (aw_valid_q && bus.axi_awready) aw_valid_d = 1'b0;
                if (w_valid_q && bus.axi_wready) w_valid_d = 1'b0;
                if (!aw_valid_d && !w_valid_d) begin
                    state_d   = STATE_WRITE_RESP;
                    b_ready_d = 1'b1;
                end
            end
            STATE_WRITE_RESP: begin
                if (bus.axi_bvalid) begin
                    state_d      = STATE_RESPOND;
                    b_ready_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_data_d  = '0;
                    resp_code_d  = (bus.axi_bid != TID) ? AXI_RESP_SLVERR : bus.axi_bresp;
                end
            end
            STATE_READ_ADDR: begin
                if (bus.axi_arready) begin
                    state_d    = STATE_READ_DATA;
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                end
            end
            STATE_READ_DATA: begin
                if (bus.axi_rvalid) begin
                    state_d      = STATE_RESPOND;
                    r_ready_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_data_d  = bus.axi_rdata;
                    resp_code_d  = (bus.axi_rid != TID || !bus.axi_rlast) ? AXI_RESP_SLVERR
                                                                          : bus.axi_rresp;
                end
            end
            STATE_RESPOND: state_d = STATE_IDLE;
            default:       state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= STATE_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            b_ready_q    <= 1'b0;
            ar_valid_q   <= 1'b0;
            r_ready_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_code_q  <= AXI_RESP_OKAY;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_valid_q   <= aw_valid_d;
            w_valid_q    <= w_valid_d;
            b_ready_q    <= b_ready_d;
            ar_valid_q   <= ar_valid_d;
            r_ready_q    <= r_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_code_q  <= resp_code_d;
        end
    end

    assign bus.cmd_ready      = (state_q == STATE_IDLE);
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_read_data = resp_data_q;
    assign bus.resp_code      = resp_code_q;

    assign bus.axi_awvalid = aw_valid_q;
    assign bus.axi_awaddr  = addr_q;
    assign bus.axi_awid    = TID;
    assign bus.axi_awlen   = 8'd0;
    assign bus.axi_awsize  = AXI_SIZE_WORD;
    assign bus.axi_awburst = AXI_BURST_INCR;

    assign bus.axi_wvalid = w_valid_q;
    assign bus.axi_wdata  = wdata_q;
    assign bus.axi_wstrb  = wstrb_q;
    assign bus.axi_wlast  = 1'b1;

    assign bus.axi_bready = b_ready_q;

    assign bus.axi_arvalid = ar_valid_q;
    assign bus.axi_araddr  = addr_q;
    assign bus.axi_arid    = TID;
    assign bus.axi_arlen   = 8'd0;
    assign bus.axi_arsize  = AXI_SIZE_WORD;
    assign bus.axi_arburst = AXI_BURST_INCR;

    assign bus.axi_rready = r_ready_q;

endmodule

// File: tb/tb_armleocpu_simple2axi_converter.sv
// Bench for the simple-to-AXI bridge: directed cases plus randomized stalls on every channel.
// Expected responses are queued at command acceptance and checked by an independent monitor.
module tb_armleocpu_simple2axi_converter;

    localparam int ADDR_WIDTH     = 34;
    localparam int ID_WIDTH       = 4;
    localparam int TRANSACTION_ID = 0;
    localparam logic [ID_WIDTH-1:0] GOOD_ID = ID_WIDTH'(TRANSACTION_ID);
    localparam logic [ID_WIDTH-1:0] BAD_ID  = ID_WIDTH'(TRANSACTION_ID + 1);

    typedef struct {
        bit                    write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           wdata;
        logic [3:0]            strb;
        logic [31:0]           rdata;
        logic [1:0]            resp;
        bit                    id_err;
        bit                    last_err;
        int                    aw_d;
        int                    w_d;
        int                    ar_d;
        int                    r_d;
        int                    b_d;
    } txn_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  code;
        int          lat;
        int          accept_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t exp_q[$];

    armleocpu_simple2axi_converter_if #(.ADDR_WIDTH(ADDR_WIDTH), .ID_WIDTH(ID_WIDTH)) bus ();

    armleocpu_simple2axi_converter #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .ID_WIDTH(ID_WIDTH),
        .TRANSACTION_ID(TRANSACTION_ID)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void checkOutput(input string name, input logic [63:0] actual,
                                        input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endfunction

    function automatic void report_timeout(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got no handshake, expected one within 64 cycles (cycle %0d)", name, cyc);
    endfunction

    // Reference model: outcome follows from the request and the slave's chosen answer alone
    function automatic exp_t expect_of(input txn_t t);
        exp_t e;
        e.accept_cyc = 0;
        if (t.addr[1:0] != 2'b00) begin
            e.data = 32'd0;
            e.code = 2'b10;
            e.lat  = 1;
        end else if (t.write) begin
            e.data = 32'd0;
            e.code = t.id_err ? 2'b10 : t.resp;
            e.lat  = 3 + ((t.aw_d > t.w_d) ? t.aw_d : t.w_d) + t.b_d;
        end else begin
            e.data = t.rdata;
            e.code = (t.id_err || t.last_err) ? 2'b10 : t.resp;
            e.lat  = 3 + t.ar_d + t.r_d;
        end
        return e;
    endfunction

    function automatic txn_t make_txn(input bit write, input logic [ADDR_WIDTH-1:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] strb,
                                      input logic [31:0] rdata, input logic [1:0] resp);
        txn_t t;
        t.write = write;  t.addr = addr;   t.wdata = wdata; t.strb = strb;
        t.rdata = rdata;  t.resp = resp;   t.id_err = 1'b0; t.last_err = 1'b0;
        t.aw_d = 0; t.w_d = 0; t.ar_d = 0; t.r_d = 0; t.b_d = 0;
        return t;
    endfunction

    task automatic issue_cmd(input txn_t t, output bit ok);
        int   g = 0;
        exp_t e;
        bus.cmd_valid            = 1'b1;
        bus.cmd_write            = t.write;
        bus.cmd_address          = t.addr;
        bus.cmd_write_data       = t.wdata;
        bus.cmd_write_byteenable = t.strb;
        while (!bus.cmd_ready && g < 64) begin
            @(negedge clk);
            g++;
        end
        ok = bus.cmd_ready;
        if (!ok) begin
            report_timeout("cmd_accept");
            bus.cmd_valid = 1'b0;
            return;
        end
        e = expect_of(t);
        e.accept_cyc = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checkOutput("cmd_ready_busy", bus.cmd_ready, 1'b0);
    endtask

    task automatic serve_write(input txn_t t);
        int k = 0;
        bit aw_done = 1'b0;
        bit w_done = 1'b0;
        while (!(aw_done && w_done) && k < 64) begin
            if (k == 0) begin
                checkOutput("awlen", bus.axi_awlen, 0);
                checkOutput("awsize", bus.axi_awsize, 2);
                checkOutput("awburst", bus.axi_awburst, 1);
                checkOutput("awid", bus.axi_awid, GOOD_ID);
            end
            if (!aw_done) begin
                checkOutput("awvalid_held", bus.axi_awvalid, 1'b1);
                checkOutput("awaddr", bus.axi_awaddr, t.addr);
                if (k >= t.aw_d) begin bus.axi_awready = 1'b1; aw_done = 1'b1; end
            end else begin
                bus.axi_awready = 1'b0;
                checkOutput("awvalid_drop", bus.axi_awvalid, 1'b0);
            end
            if (!w_done) begin
                checkOutput("wvalid_held", bus.axi_wvalid, 1'b1);
                checkOutput("wdata", bus.axi_wdata, t.wdata);
                checkOutput("wstrb", bus.axi_wstrb, t.strb);
                checkOutput("wlast", bus.axi_wlast, 1'b1);
                if (k >= t.w_d) begin bus.axi_wready = 1'b1; w_done = 1'b1; end
            end else begin
                bus.axi_wready = 1'b0;
                checkOutput("wvalid_drop", bus.axi_wvalid, 1'b0);
            end
            @(negedge clk);
            k++;
        end
        bus.axi_awready = 1'b0;
        bus.axi_wready  = 1'b0;
        if (!(aw_done && w_done)) begin report_timeout("aw_w_handshake"); return; end
        checkOutput("awvalid_drop", bus.axi_awvalid, 1'b0);
        checkOutput("wvalid_drop", bus.axi_wvalid, 1'b0);
        repeat (t.b_d) @(negedge clk);
        bus.axi_bvalid = 1'b1;
        bus.axi_bresp  = t.resp;
        bus.axi_bid    = t.id_err ? BAD_ID : GOOD_ID;
        k = 0;
        while (!bus.axi_bready && k < 64) begin @(negedge clk); k++; end
        if (!bus.axi_bready) begin report_timeout("b_handshake"); bus.axi_bvalid = 1'b0; return; end
        @(negedge clk);
        bus.axi_bvalid = 1'b0;
    endtask

    task automatic serve_read(input txn_t t);
        int k = 0;
        bit done = 1'b0;
        while (!done && k < 64) begin
            if (k == 0) begin
                checkOutput("arlen", bus.axi_arlen, 0);
                checkOutput("arsize", bus.axi_arsize, 2);
                checkOutput("arburst", bus.axi_arburst, 1);
                checkOutput("arid", bus.axi_arid, GOOD_ID);
            end
            checkOutput("arvalid_held", bus.axi_arvalid, 1'b1);
            checkOutput("araddr", bus.axi_araddr, t.addr);
            if (k >= t.ar_d) begin bus.axi_arready = 1'b1; done = 1'b1; end
            @(negedge clk);
            k++;
        end
        bus.axi_arready = 1'b0;
        if (!done) begin report_timeout("ar_handshake"); return; end
        checkOutput("arvalid_drop", bus.axi_arvalid, 1'b0);
        repeat (t.r_d) @(negedge clk);
        bus.axi_rvalid = 1'b1;
        bus.axi_rdata  = t.rdata;
        bus.axi_rresp  = t.resp;
        bus.axi_rid    = t.id_err ? BAD_ID : GOOD_ID;
        bus.axi_rlast  = !t.last_err;
        k = 0;
        while (!bus.axi_rready && k < 64) begin @(negedge clk); k++; end
        if (!bus.axi_rready) begin report_timeout("r_handshake"); bus.axi_rvalid = 1'b0; return; end
        @(negedge clk);
        bus.axi_rvalid = 1'b0;
    endtask

    task automatic wait_resp();
        int g = 0;
        while (exp_q.size() != 0 && g < 64) begin @(negedge clk); g++; end
        if (exp_q.size() != 0) begin
            report_timeout("resp_valid");
            exp_q.delete();
        end
    endtask

    task automatic applyStimulus(input txn_t t);
        bit ok;
        issue_cmd(t, ok);
        if (!ok) return;
        if (t.addr[1:0] != 2'b00) begin
            checkOutput("no_axi_misaligned", {bus.axi_awvalid, bus.axi_wvalid, bus.axi_arvalid}, 0);
            @(negedge clk);
            checkOutput("no_axi_misaligned", {bus.axi_awvalid, bus.axi_wvalid, bus.axi_arvalid}, 0);
        end else if (t.write) begin
            serve_write(t);
        end else begin
            serve_read(t);
        end
        wait_resp();
    endtask

    // Monitor: pairs every response pulse with the oldest queued expectation
    initial begin : monitor
        bit   prev_valid = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                continue;
            end
            if (bus.resp_valid) begin
                checkOutput("resp_pulse_width", prev_valid, 1'b0);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_resp", bus.resp_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("resp_read_data", bus.resp_read_data, e.data);
                    checkOutput("resp_code", bus.resp_code, e.code);
                    checkOutput("resp_latency", 64'(cyc - e.accept_cyc), 64'(e.lat));
                end
            end
            prev_valid = bus.resp_valid;
        end
    end

    initial begin : watchdog
        wait (cyc >= 90000);
        $display("[TB] FAIL watchdog: got cycle %0d, expected completion before 90000", cyc);
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : stimulus
        txn_t t;
        bit   ok;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_address = '0;
        bus.cmd_write_data = '0; bus.cmd_write_byteenable = '0;
        bus.axi_awready = 1'b0; bus.axi_wready = 1'b0; bus.axi_arready = 1'b0;
        bus.axi_bvalid = 1'b0; bus.axi_bresp = 2'b00; bus.axi_bid = '0;
        bus.axi_rvalid = 1'b0; bus.axi_rresp = 2'b00; bus.axi_rid = '0;
        bus.axi_rdata = '0; bus.axi_rlast = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_valids", {bus.axi_awvalid, bus.axi_wvalid, bus.axi_arvalid,
                                     bus.axi_bready, bus.axi_rready, bus.resp_valid}, 0);
        checkOutput("reset_resp_data", bus.resp_read_data, 0);
        checkOutput("reset_resp_code", bus.resp_code, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("cmd_ready_after_reset", bus.cmd_ready, 1'b1);

        // Aligned read with a slow arready
        t = make_txn(1'b0, 34'h0_0000_4000, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00);
        t.ar_d = 3;
        applyStimulus(t);

        // Write where W completes two cycles before AW, slave answers SLVERR
        t = make_txn(1'b1, 34'h0_0000_BFF8, 32'h12345678, 4'b0011, 32'h0, 2'b10);
        t.aw_d = 2;
        applyStimulus(t);

        // Misaligned write stays off the bus
        t = make_txn(1'b1, 34'h0_0000_1002, 32'hCAFEF00D, 4'hF, 32'h0, 2'b00);
        applyStimulus(t);

        // Wrong rid forces SLVERR, then a clean back-to-back read
        t = make_txn(1'b0, 34'h0_0000_2000, 32'h0, 4'h0, 32'h0BADF00D, 2'b00);
        t.id_err = 1'b1;
        applyStimulus(t);
        t = make_txn(1'b0, 34'h0_0000_2004, 32'h0, 4'h0, 32'h13572468, 2'b00);
        applyStimulus(t);

        // Reset while awvalid waits for awready
        t = make_txn(1'b1, 34'h0_0000_3000, 32'hA5A5A5A5, 4'hF, 32'h0, 2'b00);
        issue_cmd(t, ok);
        if (ok) begin
            checkOutput("awvalid_before_reset", bus.axi_awvalid, 1'b1);
            checkOutput("wvalid_before_reset", bus.axi_wvalid, 1'b1);
            #2 rst_n = 1'b0;
            #1;
            checkOutput("async_reset_valids", {bus.axi_awvalid, bus.axi_wvalid, bus.axi_arvalid,
                                               bus.axi_bready, bus.axi_rready, bus.resp_valid}, 0);
            checkOutput("async_reset_resp_code", bus.resp_code, 0);
            exp_q.delete();
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            checkOutput("cmd_ready_after_midreset", bus.cmd_ready, 1'b1);
        end
        t = make_txn(1'b0, 34'h0_0000_3000, 32'h0, 4'h0, 32'h600DCAFE, 2'b00);
        applyStimulus(t);

        // Best-case write with every slave channel ready at once
        t = make_txn(1'b1, 34'h2_1000_0010, 32'h89ABCDEF, 4'b1100, 32'h0, 2'b00);
        applyStimulus(t);

        // Randomized mix with stalls on all five channels
        for (int i = 0; i < 1000; i++) begin
            t.write    = ($urandom_range(0, 1) == 1);
            t.addr     = {2'($urandom_range(0, 3)), 32'($urandom())};
            if ($urandom_range(0, 7) != 0) t.addr[1:0] = 2'b00;
            t.wdata    = $urandom();
            t.strb     = 4'($urandom_range(0, 15));
            t.rdata    = $urandom();
            t.resp     = 2'($urandom_range(0, 3));
            t.id_err   = ($urandom_range(0, 9) == 0);
            t.last_err = !t.write && ($urandom_range(0, 9) == 0);
            t.aw_d     = $urandom_range(0, 3);
            t.w_d      = $urandom_range(0, 3);
            t.ar_d     = $urandom_range(0, 3);
            t.r_d      = $urandom_range(0, 3);
            t.b_d      = $urandom_range(0, 3);
            applyStimulus(t);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
